// File: rtl/fetch_pkg.sv
// Shared definitions for the 9-bit ISA fetch path.
// The decode stage imports the same instruction field layout.
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 9;

    localparam logic [INSTR_W-1:0] HALT_WORD = 9'b110110000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

    // What the fetch stage does on the coming edge, in priority-resolved form
    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_START  = 3'd1,
        ACT_BRANCH = 3'd2,
        ACT_HOLD   = 3'd3,
        ACT_FETCH  = 3'd4,
        ACT_HALT   = 3'd5
    } fetch_act_e;

    typedef struct packed {
        logic       format;
        logic [3:0] opcode;
        logic       sign;
        logic [2:0] operand;
    } instr_fields_t;

    function automatic logic [7:0] instr_immediate(input logic [INSTR_W-1:0] word);
        return word[7:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control inputs, ROM return path and IF/ID outputs.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic               start;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_valid;
    logic               halted;
    logic [15:0]        instr_count;

    modport slave (
        input  start, stall, branch_taken, branch_target, instr_in,
        output pc_out, if_instr, if_pc, if_valid, halted, instr_count
    );

    modport master (
        output start, stall, branch_taken, branch_target, instr_in,
        input  pc_out, if_instr, if_pc, if_valid, halted, instr_count
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC and action selection for the fetch stage.
// Priority in RUN: branch > stall > halt > increment.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    START_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_WORD
) (
    input  logic [1:0]         state,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_next,
    output fetch_act_e         act
);

    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    always_comb begin
        act = ACT_NONE;
        case (state)
            ST_RUN: begin
                if (branch_taken)             act = ACT_BRANCH;
                else if (stall)               act = ACT_HOLD;
                else if (instr_in == HALT_INSTR) act = ACT_HALT;
                else                          act = ACT_FETCH;
            end
            // A branch arriving after halt comes from an older instruction,
            // so the halt was speculative and the redirect takes precedence.
            ST_HALT: begin
                if (branch_taken) act = ACT_BRANCH;
                else if (start)   act = ACT_START;
            end
            default: begin
                if (start) act = ACT_START;
            end
        endcase
    end

    always_comb begin
        pc_next = pc;
        case (act)
            ACT_START:  pc_next = START_PC;
            ACT_BRANCH: pc_next = branch_target;
            ACT_FETCH:  pc_next = pc + 1'b1;
            default:    pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, captures ROM words into the IF/ID register,
// handles start, stall, branch flush and halt, and counts fetched instructions.
module instr_fetch_unit #(
    parameter logic [fetch_pkg::PC_W-1:0]    START_PC  = 16'd0,
    parameter logic [fetch_pkg::INSTR_W-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_unit_if.slave  bus
);
    import fetch_pkg::*;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]         state_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [PC_W-1:0]    if_pc_reg;
    logic               valid_reg;
    logic               halted_reg;
    logic [15:0]        count_reg;

    logic [PC_W-1:0]    pc_next;
    fetch_act_e         act;

    fetch_next_pc #(
        .START_PC   (START_PC),
        .HALT_INSTR (HALT_WORD)
    ) u_next_pc (
        .state         (state_reg),
        .start         (bus.start),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .instr_in      (bus.instr_in),
        .pc            (pc_reg),
        .pc_next       (pc_next),
        .act           (act)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            instr_reg  <= '0;
            if_pc_reg  <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            pc_reg <= pc_next;
            case (act)
                ACT_START: begin
                    count_reg  <= '0;
                    halted_reg <= 1'b0;
                    valid_reg  <= 1'b0;
                    state_reg  <= ST_RUN;
                end
                ACT_BRANCH: begin
                    valid_reg  <= 1'b0;
                    halted_reg <= 1'b0;
                    state_reg  <= ST_RUN;
                end
                ACT_HOLD: begin
                end
                ACT_FETCH, ACT_HALT: begin
                    instr_reg <= bus.instr_in;
                    if_pc_reg <= pc_reg;
                    valid_reg <= 1'b1;
                    if (count_reg != 16'hFFFF)
                        count_reg <= count_reg + 1'b1;
                    if (act == ACT_HALT) begin
                        halted_reg <= 1'b1;
                        state_reg  <= ST_HALT;
                    end
                end
                default: begin
                    // Idle, or parked in HALT: the IF/ID slot carries no instruction
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out      = pc_reg;
    assign bus.if_instr    = instr_reg;
    assign bus.if_pc       = if_pc_reg;
    assign bus.if_valid    = valid_reg;
    assign bus.halted      = halted_reg;
    assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_instr_fetch_unit;

    localparam logic [8:0] HALT_W = 9'b110110000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.START_PC(16'd0), .HALT_WORD(HALT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] rom [0:65535];
    assign bus.instr_in = rom[bus.pc_out];

    // Behavioural model: 0=idle 1=run 2=halt
    int          m_state;
    int          m_pc;
    logic [8:0]  m_instr;
    int          m_ifpc;
    logic        m_valid;
    logic        m_halted;
    int          m_cnt;

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_instr = 9'd0; m_ifpc = 0;
        m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [8:0] w;
        w = rom[m_pc];
        if (m_state == 0) begin
            m_valid = 1'b0;
            if (bus.start) begin m_pc = 0; m_cnt = 0; m_state = 1; end
        end else if (m_state == 1) begin
            if (bus.branch_taken) begin
                m_pc = int'(bus.branch_target); m_valid = 1'b0;
            end else if (!bus.stall) begin
                m_instr = w; m_ifpc = m_pc; m_valid = 1'b1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (w == HALT_W) begin m_halted = 1'b1; m_state = 2; end
                else m_pc = (m_pc + 1) % 65536;
            end
        end else begin
            m_valid = 1'b0;
            if (bus.branch_taken) begin
                m_pc = int'(bus.branch_target); m_halted = 1'b0; m_state = 1;
            end else if (bus.start) begin
                m_pc = 0; m_halted = 1'b0; m_cnt = 0; m_state = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic s, input logic st, input logic bt, input logic [15:0] tgt);
        bus.start = s; bus.stall = st; bus.branch_taken = bt; bus.branch_target = tgt;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 16'h0);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.pc_out !== 16'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0000", bus.pc_out); end
        n_checks++; if (bus.if_instr !== 9'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=000", bus.if_instr); end
        n_checks++; if (bus.if_pc !== 16'h0) begin n_fail++; $display("FAIL reset_ifpc got=%h exp=0000", bus.if_pc); end
        n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.if_valid); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        n_checks++; if (bus.instr_count !== 16'h0) begin n_fail++; $display("FAIL reset_count got=%h exp=0000", bus.instr_count); end
        @(negedge clk);
        reset_n = 1'b1;
        // IDLE ignores branch and stall
        set_in(0, 1, 1, 16'h0033);
        tick();
        n_checks++; if (bus.pc_out !== 16'h0) begin n_fail++; $display("FAIL idle_ignore_branch got=%h exp=0000", bus.pc_out); end
        set_in(0, 0, 0, 16'h0);
        $display("reset: pc=%h valid=%b count=%0d", bus.pc_out, bus.if_valid, bus.instr_count);
    endtask

    task automatic test_sequential();
        set_in(1, 0, 0, 16'h0);
        tick();
        set_in(0, 0, 0, 16'h0);
        n_checks++; if (bus.pc_out !== 16'd0) begin n_fail++; $display("FAIL seq_start_pc got=%h exp=0000", bus.pc_out); end
        n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_start_valid got=%b exp=0", bus.if_valid); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            $display("seq: pc=%h if_pc=%h instr=%h valid=%b count=%0d", bus.pc_out, bus.if_pc, bus.if_instr, bus.if_valid, bus.instr_count);
            n_checks++; if (bus.pc_out !== 16'(k)) begin n_fail++; $display("FAIL seq_pc got=%h exp=%h", bus.pc_out, 16'(k)); end
            n_checks++; if (bus.if_pc !== 16'(k - 1)) begin n_fail++; $display("FAIL seq_ifpc got=%h exp=%h", bus.if_pc, 16'(k - 1)); end
            n_checks++; if (bus.if_instr !== 9'(k - 1) || bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_instr got=%h/%b exp=%h/1", bus.if_instr, bus.if_valid, 9'(k - 1)); end
        end
        n_checks++; if (bus.instr_count !== 16'd3) begin n_fail++; $display("FAIL seq_count got=%0d exp=3", bus.instr_count); end
    endtask

    task automatic test_stall();
        logic [8:0]  held_instr;
        logic [15:0] held_cnt;
        tick(); tick();
        n_checks++; if (bus.pc_out !== 16'd5) begin n_fail++; $display("FAIL stall_setup_pc got=%h exp=0005", bus.pc_out); end
        held_instr = bus.if_instr;
        held_cnt = 16'(m_cnt);
        set_in(0, 1, 0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("stall: pc=%h instr=%h count=%0d", bus.pc_out, bus.if_instr, bus.instr_count);
            n_checks++; if (bus.pc_out !== 16'd5 || bus.if_instr !== held_instr || bus.instr_count !== held_cnt)
                begin n_fail++; $display("FAIL stall_hold got=%h/%h/%0d exp=0005/%h/%0d", bus.pc_out, bus.if_instr, bus.instr_count, held_instr, held_cnt); end
        end
        set_in(0, 0, 0, 16'h0);
        tick();
        n_checks++; if (bus.pc_out !== 16'd6 || bus.if_pc !== 16'd5) begin n_fail++; $display("FAIL stall_resume got=%h/%h exp=0006/0005", bus.pc_out, bus.if_pc); end
        n_checks++; if (bus.instr_count !== held_cnt + 16'd1) begin n_fail++; $display("FAIL stall_resume_count got=%0d exp=%0d", bus.instr_count, held_cnt + 16'd1); end
    endtask

    task automatic test_branch_flush();
        logic [15:0] held_cnt;
        held_cnt = 16'(m_cnt);
        set_in(0, 1, 1, 16'h0040);
        tick();
        set_in(0, 0, 0, 16'h0);
        $display("branch: pc=%h valid=%b", bus.pc_out, bus.if_valid);
        n_checks++; if (bus.pc_out !== 16'h0040) begin n_fail++; $display("FAIL branch_pc got=%h exp=0040", bus.pc_out); end
        n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL branch_flush got=%b exp=0", bus.if_valid); end
        n_checks++; if (bus.instr_count !== held_cnt) begin n_fail++; $display("FAIL branch_count got=%0d exp=%0d", bus.instr_count, held_cnt); end
        tick();
        n_checks++; if (bus.if_pc !== 16'h0040 || bus.if_valid !== 1'b1 || bus.pc_out !== 16'h0041)
            begin n_fail++; $display("FAIL branch_refetch got=%h/%b/%h exp=0040/1/0041", bus.if_pc, bus.if_valid, bus.pc_out); end
    endtask

    task automatic run_to_halt(input string tag);
        int budget;
        set_in(0, 0, 1, 16'd120);
        tick();
        set_in(0, 0, 0, 16'h0);
        budget = 0;
        while (bus.halted !== 1'b1 && budget < 20) begin tick(); budget++; end
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL %s_timeout halted=%b exp=1", tag, bus.halted); end
    endtask

    task automatic test_halt_restart();
        rom[126] = HALT_W;
        run_to_halt("halt");
        $display("halt: pc=%h instr=%h valid=%b halted=%b", bus.pc_out, bus.if_instr, bus.if_valid, bus.halted);
        n_checks++; if (bus.if_instr !== 9'h1B0 || bus.if_valid !== 1'b1 || bus.if_pc !== 16'd126)
            begin n_fail++; $display("FAIL halt_capture got=%h/%b/%h exp=1b0/1/007e", bus.if_instr, bus.if_valid, bus.if_pc); end
        n_checks++; if (bus.pc_out !== 16'd126) begin n_fail++; $display("FAIL halt_pc got=%h exp=007e", bus.pc_out); end
        set_in(0, 1, 0, 16'h0);
        tick();
        n_checks++; if (bus.if_valid !== 1'b0 || bus.halted !== 1'b1 || bus.pc_out !== 16'd126)
            begin n_fail++; $display("FAIL halt_park got=%b/%b/%h exp=0/1/007e", bus.if_valid, bus.halted, bus.pc_out); end
        set_in(1, 0, 0, 16'h0);
        tick();
        set_in(0, 0, 0, 16'h0);
        n_checks++; if (bus.pc_out !== 16'd0 || bus.halted !== 1'b0 || bus.instr_count !== 16'd0)
            begin n_fail++; $display("FAIL halt_restart got=%h/%b/%0d exp=0000/0/0", bus.pc_out, bus.halted, bus.instr_count); end
    endtask

    task automatic test_halt_cancel();
        run_to_halt("cancel");
        tick();
        set_in(1, 0, 1, 16'h0010);
        tick();
        set_in(0, 0, 0, 16'h0);
        $display("cancel: pc=%h halted=%b", bus.pc_out, bus.halted);
        n_checks++; if (bus.halted !== 1'b0 || bus.pc_out !== 16'h0010 || bus.if_valid !== 1'b0)
            begin n_fail++; $display("FAIL cancel_redirect got=%b/%h/%b exp=0/0010/0", bus.halted, bus.pc_out, bus.if_valid); end
        tick();
        n_checks++; if (bus.pc_out !== 16'h0011 || bus.if_pc !== 16'h0010 || bus.if_valid !== 1'b1)
            begin n_fail++; $display("FAIL cancel_run got=%h/%h/%b exp=0011/0010/1", bus.pc_out, bus.if_pc, bus.if_valid); end
    endtask

    task automatic test_wrap();
        set_in(0, 0, 1, 16'hFFFF);
        tick();
        set_in(0, 0, 0, 16'h0);
        n_checks++; if (bus.pc_out !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_setup got=%h exp=ffff", bus.pc_out); end
        tick();
        $display("wrap: pc=%h if_pc=%h instr=%h", bus.pc_out, bus.if_pc, bus.if_instr);
        n_checks++; if (bus.pc_out !== 16'h0000 || bus.if_pc !== 16'hFFFF || bus.if_instr !== 9'h1FF)
            begin n_fail++; $display("FAIL wrap_pc got=%h/%h/%h exp=0000/ffff/1ff", bus.pc_out, bus.if_pc, bus.if_instr); end
    endtask

    task automatic test_random();
        logic [8:0] w;
        for (int a = 0; a < 512; a++) begin
            w = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 39) == 0) w = HALT_W;
            rom[a] = w;
        end
        for (int c = 0; c < 300; c++) begin
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 9) == 0, 16'($urandom_range(0, 511)));
            tick();
            $display("rand %0d: pc=%h if_pc=%h instr=%h valid=%b halted=%b count=%0d",
                     c, bus.pc_out, bus.if_pc, bus.if_instr, bus.if_valid, bus.halted, bus.instr_count);
            n_checks++; if (bus.pc_out !== 16'(m_pc)) begin n_fail++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", c, bus.pc_out, 16'(m_pc)); end
            n_checks++; if (bus.if_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, bus.if_valid, m_valid); end
            n_checks++; if (bus.if_instr !== m_instr || bus.if_pc !== 16'(m_ifpc))
                begin n_fail++; $display("FAIL rand_ifid cyc=%0d got=%h/%h exp=%h/%h", c, bus.if_instr, bus.if_pc, m_instr, 16'(m_ifpc)); end
            n_checks++; if (bus.halted !== m_halted) begin n_fail++; $display("FAIL rand_halted cyc=%0d got=%b exp=%b", c, bus.halted, m_halted); end
            n_checks++; if (bus.instr_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, bus.instr_count, m_cnt); end
        end
        set_in(0, 0, 0, 16'h0);
    endtask

    task automatic test_async_reset();
        rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h004;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        set_in(1, 0, 0, 16'h0);
        tick();
        set_in(0, 0, 0, 16'h0);
        tick(); tick(); tick();
        n_checks++; if (bus.pc_out !== 16'd3 || bus.if_valid !== 1'b1 || bus.instr_count !== 16'd3)
            begin n_fail++; $display("FAIL async_setup got=%h/%b/%0d exp=0003/1/3", bus.pc_out, bus.if_valid, bus.instr_count); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        $display("async: pc=%h instr=%h if_pc=%h valid=%b halted=%b count=%0d",
                 bus.pc_out, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.instr_count);
        n_checks++; if ({bus.pc_out, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.instr_count} !== 59'd0)
            begin n_fail++; $display("FAIL async_reset got=%h/%h/%h/%b/%b/%h exp=all zero", bus.pc_out, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.instr_count); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) rom[a] = 9'(a);
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_branch_flush();
        test_halt_restart();
        test_halt_cancel();
        test_wrap();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
